// File: rtl/mem_stream_loader.sv
// Run-time loader for a small byte-wide table: a start command sets base/count,
// then a valid/ready stream fills consecutive (wrapping) entries. Registered read port.
module mem_stream_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] arr [DEPTH];
  logic              hs;

  assign hs   = in_valid & in_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count != '0) ? LOAD : DONE;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && remaining == 1) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (state == IDLE && start && count != '0) begin
      ptr       <= base_addr;
      remaining <= count;
    end else if (hs) begin
      ptr       <= ptr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // Reset clears the whole table, so a load aborted by reset leaves no partial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) arr[i] <= '0;
    end else if (hs) begin
      arr[ptr] <= in_data;
    end
  end

  // Read samples the pre-write contents, giving read-before-write on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= arr[raddr];
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed self-checking bench for mem_stream_loader: load, wrap/stall,
// overwrite, zero count, read-during-write and reset mid-load.
module tb_mem_stream_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] count;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [1:0] raddr;
  logic [7:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_stream_loader #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .done(done), .raddr(raddr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] expected, input string tag);
    raddr = a;
    step();
    chk(tag, {24'd0, rdata}, {24'd0, expected});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    in_valid = 1'b0; in_data = '0; raddr = '0;
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_busy",     {31'd0, busy},     0);
    chk("rst_done",     {31'd0, done},     0);
    chk("rst_rdata",    {24'd0, rdata},    0);
    rst_n = 1'b1;
    rd(2'd0, 8'h00, "idle_rd0");
    rd(2'd1, 8'h00, "idle_rd1");
    rd(2'd2, 8'h00, "idle_rd2");
    rd(2'd3, 8'h00, "idle_rd3");

    // Basic load: base 0, count 4
    start = 1'b1; base_addr = 2'd0; count = 3'd4;
    step();
    chk("basic_in_ready", {31'd0, in_ready}, 1);
    chk("basic_busy",     {31'd0, busy},     1);
    start = 1'b0; in_valid = 1'b1;
    in_data = 8'hA1; step();
    chk("basic_no_done_early", {31'd0, done}, 0);
    in_data = 8'hB2; step();
    in_data = 8'hC3; step();
    in_data = 8'hD4; step();
    chk("basic_done",      {31'd0, done},     1);
    chk("basic_done_nrdy", {31'd0, in_ready}, 0);
    in_valid = 1'b0;
    step();
    chk("basic_done_clr", {31'd0, done}, 0);
    chk("basic_idle",     {31'd0, busy}, 0);
    rd(2'd0, 8'hA1, "basic_rd0");
    rd(2'd1, 8'hB2, "basic_rd1");
    rd(2'd2, 8'hC3, "basic_rd2");
    rd(2'd3, 8'hD4, "basic_rd3");

    // Wrap and stall: base 3, count 3
    start = 1'b1; base_addr = 2'd3; count = 3'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_valid = 1'b0; step();
    chk("stall_rdy_a", {31'd0, in_ready}, 1);
    step();
    chk("stall_rdy_b", {31'd0, in_ready}, 1);
    in_valid = 1'b1; in_data = 8'h22; step();
    in_valid = 1'b0; step(); step();
    chk("stall_busy", {31'd0, busy}, 1);
    in_valid = 1'b1; in_data = 8'h33; step();
    chk("wrap_done", {31'd0, done}, 1);
    in_valid = 1'b0; step();
    rd(2'd3, 8'h11, "wrap_rd3");
    rd(2'd0, 8'h22, "wrap_rd0");
    rd(2'd1, 8'h33, "wrap_rd1");
    rd(2'd2, 8'hC3, "wrap_rd2_keep");

    // Overwrite: count 5 from base 0, data 1..5
    start = 1'b1; base_addr = 2'd0; count = 3'd5;
    step();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i);
      step();
    end
    chk("ovw_done", {31'd0, done}, 1);
    in_valid = 1'b0; step();
    rd(2'd0, 8'h05, "ovw_rd0");
    rd(2'd1, 8'h02, "ovw_rd1");
    rd(2'd2, 8'h03, "ovw_rd2");
    rd(2'd3, 8'h04, "ovw_rd3");

    // count = 0: straight to DONE, no in_ready cycle
    start = 1'b1; count = 3'd0;
    step();
    chk("zero_done",  {31'd0, done},     1);
    chk("zero_nrdy",  {31'd0, in_ready}, 0);
    chk("zero_busy",  {31'd0, busy},     1);
    start = 1'b0;
    step();
    chk("zero_done_clr", {31'd0, done}, 0);
    chk("zero_idle",     {31'd0, busy}, 0);

    // Read-during-write at address 2 (holds 0x03); start during LOAD ignored
    start = 1'b1; base_addr = 2'd2; count = 3'd1; raddr = 2'd2;
    step();
    count = 3'd0;
    in_valid = 1'b1; in_data = 8'h7E;
    step();
    chk("rdw_old", {24'd0, rdata}, 32'h03);
    chk("rdw_done", {31'd0, done}, 1);
    start = 1'b0; in_valid = 1'b0;
    step();
    chk("rdw_new",  {24'd0, rdata}, 32'h7E);
    chk("rdw_idle", {31'd0, busy},  0);

    // Reset mid-load after 2 of 4 words
    start = 1'b1; base_addr = 2'd0; count = 3'd4;
    step();
    start = 1'b0; in_valid = 1'b1;
    in_data = 8'h55; step();
    in_data = 8'h66; step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy},     0);
    chk("mid_rst_nrdy",  {31'd0, in_ready}, 0);
    chk("mid_rst_rdata", {24'd0, rdata},    0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("mid_rst_idle", {31'd0, busy}, 0);
    rd(2'd0, 8'h00, "mid_rst_rd0");
    rd(2'd1, 8'h00, "mid_rst_rd1");
    rd(2'd2, 8'h00, "mid_rst_rd2");
    rd(2'd3, 8'h00, "mid_rst_rd3");

    // Fresh load after reset
    start = 1'b1; base_addr = 2'd1; count = 3'd2;
    step();
    start = 1'b0; in_valid = 1'b1;
    in_data = 8'h9A; step();
    in_data = 8'hBC; step();
    chk("fresh_done", {31'd0, done}, 1);
    in_valid = 1'b0; step();
    rd(2'd1, 8'h9A, "fresh_rd1");
    rd(2'd2, 8'hBC, "fresh_rd2");
    rd(2'd0, 8'h00, "fresh_rd0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stream_loader.md
# mem_stream_loader

Run-time writer for the small byte-wide lookup memories used alongside our synchronous-read ROMs. It accepts a start command with a base address and word count, then takes that many bytes over a valid/ready stream and writes them into an internal register array at consecutive addresses, wrapping at the end. The array is exposed through a registered read port with the same one-cycle latency as our ROM blocks. This lets the test harness refill a table mid-simulation instead of relying only on the initial file load.

## Interface
- DATA_W, 8, width of each memory word and of the stream data
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries

- clk  input  1  single clock, all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  load request, sampled only in IDLE
- base_addr  input  ADDR_W  first write address, latched with start
- count  input  ADDR_W+1  number of words to load, latched with start
- in_valid  input  1  stream word present
- in_data  input  DATA_W  stream word
- in_ready  output  1  loader accepts a word this cycle
- busy  output  1  high in LOAD and DONE
- done  output  1  one-cycle pulse when the load completes
- raddr  input  ADDR_W  read address
- rdata  output  DATA_W  registered read data

## Operation
- State machine states: IDLE, LOAD, DONE.
- Internal registers: ptr (ADDR_W), remaining (ADDR_W+1), arr[DEPTH].
- IDLE with start=1 and count≠0: ptr←base_addr, remaining←count, next state LOAD.
- IDLE with start=1 and count=0: next state DONE. Nothing is written.
- LOAD: in_ready=1 (Moore, not gated by in_valid).
  - Handshake = in_valid & in_ready.
  - On handshake: arr[ptr]←in_data, ptr←ptr+1 mod DEPTH, remaining←remaining−1.
  - Handshake with remaining=1: next state DONE.
  - Without in_valid, state, ptr and remaining hold indefinitely. There is no timeout.
- DONE: done=1 for exactly one cycle, then IDLE. in_ready=0.
- start is ignored outside IDLE, including start held high through the load.
- After done, start may be asserted in the very next cycle (IDLE).
- Wrap-around: ptr wraps modulo DEPTH. If count>DEPTH, early entries are overwritten and the later word wins.
- busy = (state≠IDLE).
- Read port: rdata←arr[raddr] every cycle, independent of the loader state.
- Read and write to the same address in the same cycle: rdata returns the old value (read-before-write). The new value is visible one cycle later.
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE, ptr=0, remaining=0.
  - All arr entries = 0, rdata = 0.
  - in_ready=0, busy=0, done=0.
- Reset mid-load discards the partial load. Entries already written are also cleared.

## Timing
- Start to first in_ready: 1 cycle. start sampled in cycle N, in_ready high from cycle N+1.
- Throughput: one word per cycle while in_valid is held.
- The last handshake in cycle M gives done=1 in cycle M+1 and IDLE (busy=0) in cycle M+2.
- count=0: done=1 in cycle N+1, IDLE in cycle N+2.
- A write at cycle M is readable with raddr presented at M+1; rdata is valid at M+2.
- Read latency: 1 cycle from raddr to rdata.

## Test plan
- Reset then idle: with rst_n low, all outputs are 0. After release, read addresses 0–3 -> rdata=0x00 for each.
- Basic load: base=0, count=4, stream 0xA1,0xB2,0xC3,0xD4 with in_valid held -> done pulses on the cycle after the 4th handshake. Reads of 0..3 return A1,B2,C3,D4.
- Wrap and stall: base=3, count=3, data 0x11,0x22,0x33, with in_valid dropped for 2 cycles between words -> arr[3]=11, arr[0]=22, arr[1]=33, arr[2] unchanged. in_ready stays high during the stall.
- Overwrite and count=0:
  - count=5 from base=0 with data 1..5 -> arr[0]=5, arr[1..3]=2,3,4.
  - count=0 -> done in the next cycle, with no in_ready high cycle.
- Read-during-write: raddr=2 while 0x7E is written to address 2 -> rdata shows the old value on the next edge and 0x7E one cycle later. start pulsed during LOAD is ignored.
- Reset mid-load: assert rst_n low after 2 of 4 words -> immediate IDLE, busy=0, all entries read 0x00. A fresh load afterwards completes normally.
